// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: 2-flop synchronizer, whole-vector debounce, sticky change
// flags with read-to-clear, optional change interrupt and a 1-cycle-latency CPU read path.
module switch_input_port #(
  parameter int unsigned      WIDTH           = 16,
  parameter int unsigned      SW_BITS         = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [WIDTH-1:0] SWITCHES_LOC    = 16'hCFFD,
  parameter logic [WIDTH-1:0] STATUS_LOC      = 16'hCFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SW_BITS-1:0] switches,
  input  logic [WIDTH-1:0]   addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wdata,
  output logic               hit,
  output logic [WIDTH-1:0]   rdata,
  output logic [SW_BITS-1:0] sw_stable,
  output logic               irq
);

  localparam int unsigned     PadBits  = WIDTH - 2 - SW_BITS;
  localparam logic [CNT_W-1:0] CountMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_BITS-1:0] sync1_q, sync2_q;
  logic [SW_BITS-1:0] cand_q, cand_d;
  logic [SW_BITS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               changed_q, changed_d;
  logic [SW_BITS-1:0] mask_q, mask_d;
  logic               irq_en_q, irq_en_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               sel_data, sel_status, status_wr, commit;

  // Only bit 0 of a status write is meaningful.
  logic unused_wdata;
  assign unused_wdata = ^wdata[WIDTH-1:1];

  assign sel_data   = rd_en && (addr == SWITCHES_LOC);
  assign sel_status = rd_en && (addr == STATUS_LOC);
  assign status_wr  = wr_en && (addr == STATUS_LOC);

  always_comb begin
    cand_d   = cand_q;
    count_d  = count_q;
    stable_d = stable_q;
    commit   = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      count_d = '0;
    end else if (count_q < CountMax) begin
      count_d = count_q + CNT_W'(1);
    end else if (cand_q != stable_q) begin
      commit   = 1'b1;
      stable_d = cand_q;
    end
  end

  // Clear first, then merge a same-cycle commit so no change event is lost.
  always_comb begin
    changed_d = changed_q;
    mask_d    = mask_q;
    if (sel_status) begin
      changed_d = 1'b0;
      mask_d    = '0;
    end
    if (commit) begin
      changed_d = 1'b1;
      mask_d    = mask_d | (cand_q ^ stable_q);
    end
  end

  always_comb begin
    irq_en_d = irq_en_q;
    if (status_wr) begin
      irq_en_d = wdata[0];
    end
    rdata_d = '0;
    if (sel_data) begin
      rdata_d = {{(WIDTH - SW_BITS){1'b0}}, stable_q};
    end else if (sel_status) begin
      rdata_d = {changed_q, irq_en_q, {PadBits{1'b0}}, mask_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      mask_q    <= '0;
      irq_en_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      sync1_q   <= switches;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      mask_q    <= mask_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
    end
  end

  assign hit       = (addr == SWITCHES_LOC) || (addr == STATUS_LOC);
  assign rdata     = rdata_q;
  assign sw_stable = stable_q;
  assign irq       = changed_q & irq_en_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port with a short debounce window and a
// sample-history reference model.
module tb_switch_input_port;

  localparam int D = 4;
  localparam logic [15:0] DATA_A = 16'hCFFD;
  localparam logic [15:0] STAT_A = 16'hCFFF;

  logic        clk;
  logic        reset;
  logic [7:0]  switches;
  logic [15:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] wdata;
  logic        hit;
  logic [15:0] rdata;
  logic [7:0]  sw_stable;
  logic        irq;

  int checks;
  int failures;

  switch_input_port #(
    .WIDTH          (16),
    .SW_BITS        (8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4),
    .SWITCHES_LOC   (DATA_A),
    .STATUS_LOC     (STAT_A)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .hit      (hit),
    .rdata    (rdata),
    .sw_stable(sw_stable),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a raw sample reaches the debouncer two edges late; a value commits once
  // D+1 consecutive delayed samples agree and it differs from the stable value.
  logic [7:0]  hist [0:D+1];
  logic [7:0]  m_stable;
  logic [7:0]  m_mask;
  logic        m_changed;
  logic        m_irq_en;
  logic [15:0] m_rdata;

  function automatic logic steady();
    for (int i = 2; i <= D + 1; i++) begin
      if (hist[i] !== hist[1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= D + 1; i++) hist[i] <= 8'h00;
      m_stable  <= 8'h00;
      m_mask    <= 8'h00;
      m_changed <= 1'b0;
      m_irq_en  <= 1'b0;
      m_rdata   <= 16'h0000;
    end else begin
      if (rd_en && addr == DATA_A) m_rdata <= {8'h00, m_stable};
      else if (rd_en && addr == STAT_A) m_rdata <= {m_changed, m_irq_en, 6'b0, m_mask};
      else m_rdata <= 16'h0000;
      if (wr_en && addr == STAT_A) m_irq_en <= wdata[0];
      if (steady() && hist[1] !== m_stable) begin
        m_stable  <= hist[1];
        m_changed <= 1'b1;
        m_mask    <= ((rd_en && addr == STAT_A) ? 8'h00 : m_mask) | (hist[1] ^ m_stable);
      end else if (rd_en && addr == STAT_A) begin
        m_changed <= 1'b0;
        m_mask    <= 8'h00;
      end
      for (int i = D + 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= switches;
    end
  end

  task automatic do_reset(input logic [7:0] sw);
    @(negedge clk);
    reset = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = 16'h0000;
    wdata = 16'h0000;
    switches = sw;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    switches = 8'hFF;
    reset = 1'b1;
    #1;
    checks++;
    if (sw_stable !== 8'h00) begin
      failures++;
      $display("FAIL reset_sw_stable: got %h want 00", sw_stable);
    end
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata: got %h want 0000", rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_hit();
    logic [15:0] a;
    logic exp;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: a = DATA_A;
        1: a = STAT_A;
        2: a = 16'hCFFE;
        3: a = 16'hCFFC;
        default: a = 16'($urandom);
      endcase
      addr = a;
      exp = (a == 16'hCFFD) || (a == 16'hCFFF);
      #1;
      checks++;
      if (hit !== exp) begin
        failures++;
        $display("FAIL hit addr=%h: got %b want %b", a, hit, exp);
      end
    end
    addr = 16'h0000;
  endtask

  task automatic test_latency();
    logic [7:0] exp;
    do_reset(8'hA5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 8'hA5 : 8'h00;
      checks++;
      if (sw_stable !== exp) begin
        failures++;
        $display("FAIL latency edge %0d: got %h want %h", k, sw_stable, exp);
      end
    end
    addr = DATA_A;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h00A5) begin
      failures++;
      $display("FAIL data_read: got %h want 00A5", rdata);
    end
  endtask

  task automatic test_short_pulse();
    do_reset(8'h00);
    repeat (6) @(negedge clk);
    switches = 8'h01;
    repeat (3) @(negedge clk);
    switches = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (sw_stable !== 8'h00) begin
        failures++;
        $display("FAIL short_pulse cycle %0d: got %h want 00", k, sw_stable);
      end
    end
    addr = STAT_A;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL short_pulse_status: got %h want 0000", rdata);
    end
  endtask

  task automatic test_irq();
    int n;
    do_reset(8'h0F);
    repeat (8) @(negedge clk);
    addr = STAT_A;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h800F) begin
      failures++;
      $display("FAIL irq_initial_status: got %h want 800F", rdata);
    end
    wr_en = 1'b1;
    wdata = 16'h0001;
    @(negedge clk);
    wr_en = 1'b0;
    switches = 8'h3C;
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL irq_rise_cycles: got %0d want 7", n);
    end
    checks++;
    if (sw_stable !== 8'h3C) begin
      failures++;
      $display("FAIL irq_sw_stable: got %h want 3C", sw_stable);
    end
    rd_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rdata !== 16'hC033) begin
      failures++;
      $display("FAIL irq_status_read: got %h want C033", rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h4000) begin
      failures++;
      $display("FAIL irq_status_after_clear: got %h want 4000", rdata);
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp [0:2];
    exp[0] = 16'h8001;
    exp[1] = 16'h8002;
    exp[2] = 16'h0000;
    do_reset(8'h01);
    repeat (8) @(negedge clk);
    switches = 8'h03;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (sw_stable !== 8'h01) begin
        failures++;
        $display("FAIL collision_pre edge %0d: got %h want 01", k, sw_stable);
      end
    end
    addr = STAT_A;
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rdata !== exp[k]) begin
        failures++;
        $display("FAIL collision_read %0d: got %h want %h", k, rdata, exp[k]);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (sw_stable !== 8'h03) begin
      failures++;
      $display("FAIL collision_sw_stable: got %h want 03", sw_stable);
    end
  endtask

  task automatic test_write();
    do_reset(8'h00);
    repeat (8) @(negedge clk);
    addr = STAT_A;
    wr_en = 1'b1;
    wdata = 16'h0003;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rdata !== 16'h4000) begin
      failures++;
      $display("FAIL write_irq_en_set: got %h want 4000", rdata);
    end
    wr_en = 1'b1;
    wdata = 16'hFFFE;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (rdata !== 16'h4000) begin
      failures++;
      $display("FAIL rd_wr_same_cycle: got %h want 4000", rdata);
    end
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL write_irq_en_clear: got %h want 0000", rdata);
    end
    switches = 8'h81;
    repeat (8) @(negedge clk);
    checks++;
    if (sw_stable !== 8'h81 || irq !== 1'b0) begin
      failures++;
      $display("FAIL masked_change: got sw=%h irq=%b want sw=81 irq=0", sw_stable, irq);
    end
    addr = DATA_A;
    wr_en = 1'b1;
    wdata = 16'hFFFF;
    @(negedge clk);
    wr_en = 1'b0;
    addr = STAT_A;
    rd_en = 1'b1;
    @(negedge clk);
    addr = DATA_A;
    checks++;
    if (rdata !== 16'h8081) begin
      failures++;
      $display("FAIL data_write_ignored: got %h want 8081", rdata);
    end
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rdata !== 16'h0081) begin
      failures++;
      $display("FAIL data_after_write: got %h want 0081", rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset(8'h11);
    repeat (8) @(negedge clk);
    addr = STAT_A;
    wr_en = 1'b1;
    wdata = 16'h0001;
    @(negedge clk);
    wr_en = 1'b0;
    addr = DATA_A;
    rd_en = 1'b1;
    switches = 8'hFF;
    repeat (5) @(negedge clk);
    checks++;
    if (irq !== 1'b1 || rdata !== 16'h0011) begin
      failures++;
      $display("FAIL reset_mid_setup: got irq=%b rdata=%h want irq=1 rdata=0011", irq, rdata);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || rdata !== 16'h0000 || sw_stable !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_async: got irq=%b rdata=%h sw=%h want 0/0000/00",
               irq, rdata, sw_stable);
    end
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 8'hFF : 8'h00;
      checks++;
      if (sw_stable !== exp) begin
        failures++;
        $display("FAIL reset_mid_redebounce edge %0d: got %h want %h", k, sw_stable, exp);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [15:0] exp_rd;
    logic exp_irq;
    do_reset(8'($urandom));
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_irq = m_changed & m_irq_en;
      exp_rd = m_rdata;
      checks++;
      if (sw_stable !== m_stable || irq !== exp_irq || rdata !== exp_rd) begin
        failures++;
        $display("FAIL random cycle %0d: got sw=%h irq=%b rdata=%h want sw=%h irq=%b rdata=%h",
                 c, sw_stable, irq, rdata, m_stable, exp_irq, exp_rd);
      end
      if (hold == 0) begin
        switches = ($urandom_range(0, 3) == 0) ? m_stable : 8'($urandom);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      case ($urandom_range(0, 3))
        0: addr = DATA_A;
        1, 2: addr = STAT_A;
        default: addr = 16'($urandom);
      endcase
      rd_en = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wdata = 16'($urandom);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    switches = 8'h00;
    addr = 16'h0000;
    rd_en = 1'b0;
    wr_en = 1'b0;
    wdata = 16'h0000;
    #12;
    test_reset();
    test_hit();
    test_latency();
    test_short_pulse();
    test_irq();
    test_collision();
    test_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
